c432_key_sweep: RTL
===================

# c432_key_sweep

Sequential key-recovery engine for the key-locked c432 netlist (4 MUX key bits p1..p4 plus 8 XOR key bits X_1..X_8). It enumerates candidate 12-bit keys, drives each one onto the locked netlist together with pseudo-random input patterns, and compares the locked outputs against an unlocked oracle copy. It reports the first key that matches on all patterns. It sits in the deobfuscation bench beside two combinational instances: the locked DUT and the oracle.

## Interface
- KEY_W, 12, key width; bit order {p1,p2,p3,p4,X_1..X_8}, with p1 as the MSB.
- PAT_W, 36, primary-input pattern width (N1..N115 in port order, N1 as the MSB).
- OUT_W, 7, compared output width {N223,N329,N370,N421,N430,N431,N432}.
- NUM_PAT, 8, patterns a key must pass; range 1..256.
- SEED, 36'h0_0000_0001, LFSR seed. A value of 0 is replaced by 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep. Sampled in IDLE or DONE only.
- key_out  out  KEY_W  candidate key, driven to the locked netlist key inputs.
- pat_out  out  PAT_W  input pattern, driven to both netlists.
- dut_out  in  OUT_W  locked-netlist outputs (combinational from key_out/pat_out).
- ref_out  in  OUT_W  oracle outputs (combinational from pat_out).
- busy  out  1  high while in RUN.
- done  out  1  high in DONE (level).
- found  out  1  valid when done=1; 1 means a key passed.
- found_key  out  KEY_W  the passing key; valid when found=1.

## Operation
- FSM states:
  - IDLE: start=1 → RUN.
  - RUN: iterates keys and patterns (below).
  - DONE: start=1 → RUN; holds otherwise.
- Entering RUN:
  - key counter k=0, pattern counter i=0, LFSR=SEED.
  - found=0, found_key=0.
- Each RUN cycle compares dut_out with ref_out for the current (key_out=k, pat_out=LFSR).
- Mismatch (key rejected):
  - if k == 2^KEY_W−1: → DONE, found=0.
  - else: k←k+1, i←0, LFSR←SEED.
- Match with i < NUM_PAT−1: i←i+1, LFSR advances one step.
- Match with i == NUM_PAT−1: → DONE, found=1, found_key=k.
- LFSR: 36-bit Fibonacci, polynomial x^36+x^25+1, shifting toward the MSB. New bit0 = bit35 XOR bit24.
- key_out and pat_out are registers and hold their last values in DONE and IDLE.
- The key counter is exactly KEY_W bits wide; termination uses the explicit k == max check, with no wrap.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, found=0.
  - found_key=0, key_out=0, pat_out=SEED.
- start sampled at edge T → busy=1 from T+1, with key 0 / pattern 0 presented during cycle T+1.
- Compare happens at the edge ending each RUN cycle, one cycle per pattern.
- Cost per rejected key: cycles up to and including the first mismatch.
- Cost for the passing key: NUM_PAT cycles.
- done/found/found_key update at the same edge that leaves RUN. busy falls at that edge.
- start=1 during RUN is ignored.
- rst=1 at any edge, including mid-sweep, wins over every other event and forces the reset values.

## Configuration
- KEY_SWEEP_REJECT_CNT_EN:
  - Defined: adds output rej_cnt (KEY_W+1 bits).
    - Cleared on reset and on entry to RUN.
    - Increments once per rejected key and holds in DONE.
    - Width allows the value 4096 when all keys are rejected.
  - Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Oracle model matches only key 12'h5A3, and mismatches on pattern 0 otherwise. Pulse start → found=1, found_key=12'h5A3, done after 1443+8=1451 RUN cycles.
- Model matches only key 12'h000 → found=1, found_key=0, done exactly 8 cycles after busy rises. pat_out sequence begins SEED, 36'h0_0000_0002, 36'h0_0000_0004.
- Model never matches → found=0 and done after 4096 RUN cycles. key_out ends at 12'hFFF.
- Model matches key 12'h5A3 on patterns 0..6 but fails pattern 7 (NUM_PAT=8); all other keys fail at once → found=0. No key ≥12'h5A4 is reported.
- Assert rst after 100 RUN cycles → next cycle busy=0, done=0, key_out=0, pat_out=SEED. start=1 pulsed mid-RUN → no restart; k is not reset.
- With KEY_SWEEP_REJECT_CNT_EN, first scenario → rej_cnt=1443. No-match scenario → rej_cnt=4096.

Source files
------------

// File: rtl/c432_key_sweep_if.sv
// c432_key_sweep_if: groups the sweep engine's control, key/pattern and result signals.
// Ports: start (in), key_out/pat_out (to both netlists), dut_out/ref_out (back from the
// netlists), busy/done/found/found_key status, rej_cnt when KEY_SWEEP_REJECT_CNT_EN is defined.
// slave = sweep engine side, master = controller / netlist side.
interface c432_key_sweep_if #(
    parameter int KEY_W = 12,
    parameter int PAT_W = 36,
    parameter int OUT_W = 7
);
    logic             start;
    logic [KEY_W-1:0] key_out;
    logic [PAT_W-1:0] pat_out;
    logic [OUT_W-1:0] dut_out;
    logic [OUT_W-1:0] ref_out;
    logic             busy;
    logic             done;
    logic             found;
    logic [KEY_W-1:0] found_key;
`ifdef KEY_SWEEP_REJECT_CNT_EN
    logic [KEY_W:0]   rej_cnt;

    modport slave (
        input  start, dut_out, ref_out,
        output key_out, pat_out, busy, done, found, found_key, rej_cnt
    );
    modport master (
        output start, dut_out, ref_out,
        input  key_out, pat_out, busy, done, found, found_key, rej_cnt
    );
`else
    modport slave (
        input  start, dut_out, ref_out,
        output key_out, pat_out, busy, done, found, found_key
    );
    modport master (
        output start, dut_out, ref_out,
        input  key_out, pat_out, busy, done, found, found_key
    );
`endif
endinterface

// File: rtl/c432_key_sweep.sv
// c432_key_sweep: brute-force key recovery for locked c432, first key matching the oracle on NUM_PAT patterns.
// Latency: one cycle per compared pattern; a rejected key costs cycles up to its first mismatch.
// Backpressure: none; start is only honoured in IDLE/DONE, ignored while busy.
// Ports: clk, rst (sync, active-high), io (c432_key_sweep_if.slave: start, key_out, pat_out,
// dut_out, ref_out, busy, done, found, found_key). Optional macro KEY_SWEEP_REJECT_CNT_EN adds
// io.rej_cnt, the count of rejected keys (KEY_W+1 bits so that all 2^KEY_W rejections fit).
module c432_key_sweep #(
    parameter int             KEY_W   = 12,
    parameter int             PAT_W   = 36,
    parameter int             OUT_W   = 7,
    parameter int             NUM_PAT = 8,
    parameter logic [PAT_W-1:0] SEED  = 36'h0_0000_0001
) (
    input  logic              clk,
    input  logic              rst,
    c432_key_sweep_if.slave   io
);
    // An all-zero Fibonacci LFSR is stuck, so a zero seed is promoted to 1.
    localparam logic [PAT_W-1:0] SEED_EFF = (SEED == '0) ? PAT_W'(1) : SEED;
    // Second tap of x^36+x^25+1 sits at bit 24.
    localparam int TAP  = PAT_W - 12;
    // Pattern index must reach 255 (NUM_PAT up to 256).
    localparam int IDX_W = 9;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [KEY_W-1:0] key_q, key_n;
    logic [PAT_W-1:0] pat_q, pat_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             found_q, found_n;
    logic [KEY_W-1:0] fkey_q, fkey_n;
    logic [KEY_W:0]   rej_q, rej_n;
    logic             mismatch;

    assign mismatch = (io.dut_out != io.ref_out);

    always_comb begin
        state_n = state;
        key_n   = key_q;
        pat_n   = pat_q;
        idx_n   = idx_q;
        found_n = found_q;
        fkey_n  = fkey_q;
        rej_n   = rej_q;
        case (state)
            IDLE, DONE: begin
                if (io.start) begin
                    state_n = RUN;
                    key_n   = '0;
                    pat_n   = SEED_EFF;
                    idx_n   = '0;
                    found_n = 1'b0;
                    fkey_n  = '0;
                    rej_n   = '0;
                end
            end
            RUN: begin
                if (mismatch) begin
                    rej_n = rej_q + (KEY_W+1)'(1);
                    // Explicit last-key check: the counter never wraps back to 0.
                    if (key_q == {KEY_W{1'b1}}) begin
                        state_n = DONE;
                        found_n = 1'b0;
                    end else begin
                        key_n = key_q + KEY_W'(1);
                        idx_n = '0;
                        pat_n = SEED_EFF;
                    end
                end else if (idx_q == LAST_IDX) begin
                    state_n = DONE;
                    found_n = 1'b1;
                    fkey_n  = key_q;
                end else begin
                    idx_n = idx_q + IDX_W'(1);
                    pat_n = {pat_q[PAT_W-2:0], pat_q[PAT_W-1] ^ pat_q[TAP]};
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            key_q   <= '0;
            pat_q   <= SEED_EFF;
            idx_q   <= '0;
            found_q <= 1'b0;
            fkey_q  <= '0;
            rej_q   <= '0;
        end else begin
            state   <= state_n;
            key_q   <= key_n;
            pat_q   <= pat_n;
            idx_q   <= idx_n;
            found_q <= found_n;
            fkey_q  <= fkey_n;
            rej_q   <= rej_n;
        end
    end

    assign io.key_out   = key_q;
    assign io.pat_out   = pat_q;
    assign io.busy      = (state == RUN);
    assign io.done      = (state == DONE);
    assign io.found     = found_q;
    assign io.found_key = fkey_q;
`ifdef KEY_SWEEP_REJECT_CNT_EN
    assign io.rej_cnt   = rej_q;
`else
    // Counter only feeds the optional output; unused otherwise.
    logic unused_rej;
    assign unused_rej = ^rej_q;
`endif
endmodule
